light_sequencer: RTL
====================

# light_sequencer

Sequencing controller for the lights selector datapath. Drives the selector's `sel` and `button` inputs so that the RGB colour path steps automatically at a fixed dwell rate. After each round of colour steps it inserts a white-light interval. It also accepts a debounced manual step button. It sits between the board push-buttons and the selector; the selector's light output is unaffected except through `sel`/`button`.

## Interface
- DWELL_CYCLES, 16: cycles each colour is held before an automatic step (≥2).
- WHITE_CYCLES, 8: cycles white light is held between rounds (≥1).
- STEPS_PER_ROUND, 6: automatic steps per round before the white interval (1..255).
- DEBOUNCE_CYCLES, 4: cycles the manual button must be stable to be accepted (≥1).
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  level-sampled request to begin sequencing.
- stop  input  1  level-sampled request to return to idle.
- man_button  input  1  raw (bouncy) manual step button, active-high.
- loop  input  1  1: repeat rounds forever; 0: return to idle after one round's white interval.
- sel  output  1  to selector `sel`; 0 = white, 1 = RGB path.
- button  output  1  one-cycle step pulse to selector `button`.
- busy  output  1  high in any state other than IDLE.
- round_cnt  output  8  completed rounds since leaving IDLE, wraps 255→0.

## Operation
- All outputs are registered. Reset values: sel=0, button=0, busy=0, round_cnt=0, state=IDLE, all counters 0, debouncer stable value 0.
- States: IDLE, COLOUR, WHITE.
- IDLE: sel=0, busy=0. If start=1 and stop=0, go to COLOUR with dwell=0, step=0, round_cnt=0.
- COLOUR: sel=1. dwell increments every cycle. When dwell==DWELL_CYCLES-1, the next cycle produces button=1, dwell=0 and step+1.
  - If the new step equals STEPS_PER_ROUND, go to WHITE with wcnt=0 in that same edge.
- WHITE: sel=0, no pulses. wcnt increments each cycle. When wcnt==WHITE_CYCLES-1, round_cnt+1 and:
  - loop=1: go to COLOUR with dwell=0, step=0.
  - loop=0: go to IDLE.
- stop=1 in COLOUR or WHITE: go to IDLE next edge. No pulse is issued that edge; round_cnt holds. stop has priority over start, dwell expiry and manual press.
- Manual button handling:
  - man_button passes a 2-flop synchroniser, then a debouncer. The accepted value changes only after DEBOUNCE_CYCLES consecutive equal synchronised samples that differ from the current accepted value.
  - A 0→1 change of the accepted value is a press.
  - A press in COLOUR produces button=1 next cycle, resets dwell to 0 and increments step, with the same round-end check.
  - A press in IDLE or WHITE is discarded.
- A press coinciding with dwell expiry produces exactly one pulse and one step increment.
- button is never high on two consecutive cycles. Worst case: a press lands on the cycle right after a pulse; its pulse is then deferred one cycle.
- step is 8 bits and dwell/wcnt are sized by $clog2 of their parameter. No counter exceeds its terminal value.

## Timing
- start seen at edge N: busy=1 and sel=1 after edge N.
- First automatic pulse is high during the cycle after edge N+DWELL_CYCLES; later pulses are every DWELL_CYCLES cycles.
- The last pulse of a round and sel→0 appear after the same edge.
- WHITE lasts exactly WHITE_CYCLES cycles, then sel=1 (loop=1) or busy=0 (loop=0).
- Manual press latency: accepted value rises DEBOUNCE_CYCLES+2 cycles after a clean man_button rise; button pulses one cycle after that.
- Asynchronous reset mid-operation clears everything immediately (sel=0, button=0). Operation restarts only on a new start after rst deasserts.

## Test plan
- Params DWELL=4, WHITE=3, STEPS=2, DEBOUNCE=2, loop=0: pulse start for 1 cycle -> sel=1, button pulses 4 and 8 cycles after start, sel=0 on the second pulse cycle, busy=0 and round_cnt=1 after 3 white cycles.
- Same params, loop=1, run 3 rounds -> 6 pulses total, white intervals of exactly 3 cycles, round_cnt=3; stop -> busy=0 next cycle, round_cnt holds 3.
- man_button toggling 0/1 each cycle for 10 cycles, then held 1 while in COLOUR -> exactly one pulse 5 cycles (2 sync + 2 debounce + 1) after the stable rise, dwell restarts (next auto pulse 4 cycles later).
- Manual press aligned to the dwell expiry cycle -> single button pulse, step advances by 1 only.
- start and stop both 1 in IDLE -> stays IDLE, busy=0; stop asserted on the dwell expiry cycle -> no pulse, IDLE.
- rst driven low mid-COLOUR between clock edges -> sel, button, busy, round_cnt all 0 immediately; no activity after release until start.

Source files
------------

// File: rtl/light_sequencer.sv
// -----------------------------------------------------------------------------
// light_sequencer
//
// Drives the lights selector's `sel` and `button` inputs. While running, the
// RGB colour path steps automatically every DWELL_CYCLES cycles. After
// STEPS_PER_ROUND steps a white-light interval of WHITE_CYCLES cycles follows.
// After that the sequencer either starts another round or returns to idle. A
// raw manual push-button is synchronised and debounced. Each accepted press
// steps the colour path early and restarts the dwell timer.
//
// Ports
//   clk         system clock, all logic on the rising edge
//   rst         asynchronous reset, active low
//   start       level request to begin sequencing (ignored unless idle)
//   stop        level request to return to idle (beats everything else)
//   man_button  raw, bouncy manual step button, active high
//   loop        1: repeat rounds forever, 0: go idle after one white interval
//   sel         selector path: 0 = white, 1 = RGB
//   button      one-cycle step pulse to the selector
//   busy        high whenever the sequencer is not idle
//   round_cnt   rounds completed since leaving idle, wraps 255 -> 0
// -----------------------------------------------------------------------------
module light_sequencer #(
  parameter int DWELL_CYCLES    = 16,  // >= 2
  parameter int WHITE_CYCLES    = 8,   // >= 1
  parameter int STEPS_PER_ROUND = 6,   // 1..255
  parameter int DEBOUNCE_CYCLES = 4    // >= 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       man_button,
  input  logic       loop,
  output logic       sel,
  output logic       button,
  output logic       busy,
  output logic [7:0] round_cnt
);

  // Counter widths. A parameter of 1 still gets a one-bit counter.
  localparam int DWELL_W = (DWELL_CYCLES    > 1) ? $clog2(DWELL_CYCLES)    : 1;
  localparam int WHITE_W = (WHITE_CYCLES    > 1) ? $clog2(WHITE_CYCLES)    : 1;
  localparam int DEB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
  localparam logic [WHITE_W-1:0] WHITE_LAST = WHITE_W'(WHITE_CYCLES - 1);
  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]         STEPS_END  = 8'(STEPS_PER_ROUND);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COLOUR = 2'd1,
    S_WHITE  = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Manual button: two-flop synchroniser followed by a debouncer.
  // ---------------------------------------------------------------------------
  logic             meta_q;
  logic             sync_q;
  logic [DEB_W-1:0] deb_cnt_q;
  logic             acc_q;     // accepted (debounced) button level
  logic             press_q;   // one-cycle flag: accepted level just rose

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q    <= 1'b0;
      sync_q    <= 1'b0;
      deb_cnt_q <= '0;
      acc_q     <= 1'b0;
      press_q   <= 1'b0;
    end else begin
      // NOTE: man_button is asynchronous to clk. meta_q may go metastable, so
      // only sync_q is read by any other logic.
      meta_q  <= man_button;
      sync_q  <= meta_q;
      press_q <= 1'b0;
      // Count consecutive samples that disagree with the accepted level. Any
      // agreeing sample restarts the count. The level flips on the
      // DEBOUNCE_CYCLES-th disagreeing sample in a row.
      if (sync_q != acc_q) begin
        if (deb_cnt_q == DEB_LAST) begin
          acc_q     <= sync_q;
          deb_cnt_q <= '0;
          press_q   <= sync_q;  // only a 0 -> 1 flip counts as a press
        end else begin
          deb_cnt_q <= deb_cnt_q + 1'b1;
        end
      end else begin
        deb_cnt_q <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM with registered outputs.
  // ---------------------------------------------------------------------------
  state_e             state_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [WHITE_W-1:0] wcnt_q;
  logic [7:0]         step_q;
  logic               pend_q;      // press waiting out a pulse on the previous cycle
  logic               sel_q;
  logic               button_q;
  logic               busy_q;
  logic [7:0]         round_cnt_q;

  logic       manual_req;
  logic       dwell_done;
  logic       step_fire;
  logic       round_end;
  logic       white_done;
  logic [7:0] step_d;

  assign manual_req = press_q | pend_q;
  assign dwell_done = (dwell_q == DWELL_LAST);
  // A manual press and a dwell expiry on the same cycle merge into one step.
  // A step is held off while button_q is high, so pulses are never back to
  // back. Only a press can be held off: dwell is 0 right after any pulse.
  assign step_fire  = (manual_req | dwell_done) & ~button_q;
  assign step_d     = step_q + 8'd1;
  assign round_end  = (step_d == STEPS_END);
  assign white_done = (wcnt_q == WHITE_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      dwell_q     <= '0;
      wcnt_q      <= '0;
      step_q      <= '0;
      pend_q      <= 1'b0;
      sel_q       <= 1'b0;
      button_q    <= 1'b0;
      busy_q      <= 1'b0;
      round_cnt_q <= '0;
    end else begin
      // NOTE: every register here uses a non-blocking assignment. All
      // decisions below therefore see the values from before this edge,
      // whatever the statement order. That includes the button_q default.
      button_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          pend_q <= 1'b0;
          if (start && !stop) begin
            state_q     <= S_COLOUR;
            sel_q       <= 1'b1;
            busy_q      <= 1'b1;
            dwell_q     <= '0;
            step_q      <= '0;
            round_cnt_q <= '0;
          end
        end

        S_COLOUR: begin
          if (stop) begin
            state_q <= S_IDLE;
            sel_q   <= 1'b0;
            busy_q  <= 1'b0;
            pend_q  <= 1'b0;
          end else if (step_fire) begin
            button_q <= 1'b1;
            dwell_q  <= '0;
            step_q   <= step_d;
            pend_q   <= 1'b0;
            // The last pulse of a round and the switch to white share an edge.
            if (round_end) begin
              state_q <= S_WHITE;
              sel_q   <= 1'b0;
              wcnt_q  <= '0;
            end
          end else begin
            if (!dwell_done) begin
              dwell_q <= dwell_q + 1'b1;
            end
            if (manual_req) begin
              pend_q <= 1'b1;
            end
          end
        end

        S_WHITE: begin
          if (stop) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (white_done) begin
            round_cnt_q <= round_cnt_q + 8'd1;
            if (loop) begin
              state_q <= S_COLOUR;
              sel_q   <= 1'b1;
              dwell_q <= '0;
              step_q  <= '0;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            wcnt_q <= wcnt_q + 1'b1;
          end
        end

        default: begin
          state_q <= S_IDLE;
          sel_q   <= 1'b0;
          busy_q  <= 1'b0;
          pend_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sel       = sel_q;
  assign button    = button_q;
  assign busy      = busy_q;
  assign round_cnt = round_cnt_q;

endmodule
